// File: rtl/bmp_rom_streamer.sv
// bmp_rom_streamer
// Reads the 54-byte BMP header from ROM address 0 and decodes it. If the
// header is valid, it streams the pixel array (row padding included) from
// address off to off+total-1 over a valid/ready byte stream. The ROM has a
// one-cycle read latency, and a 2-entry FIFO absorbs it so the stream keeps
// full rate.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a new image (ignored while busy)
//   busy / done / err     status: busy in HDR/CHECK/STREAM, done pulse,
//                         err is held high while in ERR
//   rom_valid, rom_addr   ROM read request
//   rom_data              ROM registered read data
//   img_width/height/bpp  decoded header fields
//   pix_valid/ready/data  output byte stream
//   pix_last              marks the last byte of the image
//
// state  | meaning
// IDLE   | waiting for start
// HDR    | issue header reads 0..53 and capture the returned bytes
// CHECK  | compute stride/total and validate the header
// STREAM | read the pixel array and drain it through the FIFO
// DONE   | one-cycle done pulse
// ERR    | bad header; hold err until the next start
module bmp_rom_streamer #(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_WIDTH = 8,
  parameter int HDR_BYTES  = 54
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rom_valid,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [BYTE_WIDTH-1:0] rom_data,
  output logic [15:0]           img_width,
  output logic [15:0]           img_height,
  output logic [15:0]           img_bpp,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [BYTE_WIDTH-1:0] pix_data,
  output logic                  pix_last
);

  localparam int HW = $clog2(HDR_BYTES + 1);
  localparam int WW = 64;
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHECK, S_STREAM, S_DONE, S_ERR} state_t;

  state_t state, state_nxt;

  logic [HW-1:0]         hdr_cnt, cap_idx;
  logic                  rd_pend;
  logic [7:0]            magic0, magic1;
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         iss_left, out_left;
  logic [BYTE_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fcnt;

  logic start_acc, hdr_issue, str_issue, hs, push, pop, hdr_bad;
  logic [WW-1:0] row_w, stride_w, total_w, end_w;
  logic total_unused;

  assign start_acc = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign hdr_issue = (state == S_HDR) && (hdr_cnt < HW'(HDR_BYTES));
  // A new read is allowed only when FIFO occupancy plus the read in flight
  // leaves room for its data.
  assign str_issue = (state == S_STREAM) && (iss_left != '0) &&
                     (({1'b0, fcnt} + {2'b0, rd_pend}) < 3'd2);

  assign rom_valid = hdr_issue | str_issue;
  assign rom_addr  = hdr_issue ? ADDR_WIDTH'(hdr_cnt) : (str_issue ? rd_addr : '0);

  // An empty FIFO passes returning ROM data straight through, which saves
  // a cycle of latency. If that byte stalls, it is written into the FIFO
  // and becomes the head, so pix_data keeps the same value.
  assign pix_valid = (state == S_STREAM) && ((fcnt != 2'd0) || rd_pend);
  assign pix_data  = !pix_valid ? '0 : ((fcnt != 2'd0) ? fifo_mem[rd_ptr] : rom_data);
  assign pix_last  = pix_valid && (out_left == CW'(1));
  assign hs        = pix_valid && pix_ready;
  assign push      = (state == S_STREAM) && rd_pend && !((fcnt == 2'd0) && hs);
  assign pop       = hs && (fcnt != 2'd0);

  assign busy = (state == S_HDR) || (state == S_CHECK) || (state == S_STREAM);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

  // Do the size math wide enough that a huge header cannot wrap around
  // and slip past the bound check.
  assign row_w    = ({{(WW-16){1'b0}}, img_width} * {{(WW-16){1'b0}}, img_bpp}) >> 3;
  assign stride_w = (row_w + 64'd3) & ~64'd3;
  assign total_w  = stride_w * {{(WW-16){1'b0}}, img_height};
  assign end_w    = {32'b0, off} + total_w;
  assign total_unused = ^total_w[WW-1:CW];

  assign hdr_bad = ({magic1, magic0} != 16'h4D42) ||
                   !((img_bpp == 16'd8) || (img_bpp == 16'd24)) ||
                   (img_width == 16'd0) || (img_height == 16'd0) ||
                   (end_w > (64'd1 << ADDR_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_acc) state_nxt = S_HDR;
      S_HDR:    if (hdr_cnt == HW'(HDR_BYTES)) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = hdr_bad ? S_ERR : S_STREAM;
      S_STREAM: if (hs && (out_left == CW'(1))) state_nxt = S_DONE;
      S_DONE:   state_nxt = start_acc ? S_HDR : S_IDLE;
      S_ERR:    if (start_acc) state_nxt = S_HDR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt     <= '0;
      cap_idx     <= '0;
      rd_pend     <= 1'b0;
      magic0      <= '0;
      magic1      <= '0;
      off         <= '0;
      img_width   <= '0;
      img_height  <= '0;
      img_bpp     <= '0;
      rd_addr     <= '0;
      iss_left    <= '0;
      out_left    <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fcnt        <= '0;
    end else begin
      rd_pend <= rom_valid;
      if (start_acc) hdr_cnt <= '0;
      else if (hdr_issue) hdr_cnt <= hdr_cnt + HW'(1);
      if (hdr_issue) cap_idx <= hdr_cnt;

      // Header bytes arrive one cycle after the read that fetched them.
      if (state == S_HDR && rd_pend) begin
        case (cap_idx)
          HW'(0):  magic0           <= rom_data;
          HW'(1):  magic1           <= rom_data;
          HW'(10): off[7:0]         <= rom_data;
          HW'(11): off[15:8]        <= rom_data;
          HW'(12): off[23:16]       <= rom_data;
          HW'(13): off[31:24]       <= rom_data;
          HW'(18): img_width[7:0]   <= rom_data;
          HW'(19): img_width[15:8]  <= rom_data;
          HW'(22): img_height[7:0]  <= rom_data;
          HW'(23): img_height[15:8] <= rom_data;
          HW'(28): img_bpp[7:0]     <= rom_data;
          HW'(29): img_bpp[15:8]    <= rom_data;
          default: ;
        endcase
      end

      if (state == S_CHECK) begin
        rd_addr  <= off[ADDR_WIDTH-1:0];
        iss_left <= total_w[CW-1:0];
        out_left <= total_w[CW-1:0];
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
        fcnt     <= '0;
      end else begin
        if (str_issue) begin
          rd_addr  <= rd_addr + ADDR_WIDTH'(1);
          iss_left <= iss_left - CW'(1);
        end
        if (hs) out_left <= out_left - CW'(1);
        if (push) begin
          fifo_mem[wr_ptr] <= rom_data;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: doc/bmp_rom_streamer.md
# bmp_rom_streamer

Sequencer for the BMP byte ROM. On `start` it reads the 54-byte BMP header from ROM address 0, validates and decodes it, and computes the pixel-array span. It then streams every pixel-array byte, row padding included, to the downstream binarization datapath over a valid/ready byte stream. It is the sole master of the ROM read port: it drives `rom_valid`/`rom_addr` and absorbs the ROM's one-cycle read latency, with full throughput under backpressure.

## Interface
- `ADDR_WIDTH`, 20, ROM byte-address width
- `BYTE_WIDTH`, 8, ROM data width; fixed at 8
- `HDR_BYTES`, 54, header length in bytes
- `clk`  in  1  clock
- `rst_n`  in  1  reset: asynchronous, active-low
- `start`  in  1  one-cycle pulse; accepted only in IDLE, DONE or ERR
- `busy`  out  1  high in HDR, CHECK and STREAM
- `done`  out  1  one-cycle pulse after the last stream handshake
- `err`  out  1  sticky header-error flag; cleared by the next accepted `start`
- `rom_valid`  out  1  ROM read enable
- `rom_addr`  out  ADDR_WIDTH  ROM byte address
- `rom_data`  in  8  ROM registered output; valid the cycle after `rom_valid`; holds otherwise
- `img_width`, `img_height`  out  16  decoded header fields (low 16 bits of the 32-bit fields)
- `img_bpp`  out  16  decoded bits per pixel
- `pix_valid`  out  1  stream byte valid
- `pix_ready`  in  1  downstream ready
- `pix_data`  out  8  stream byte
- `pix_last`  out  1  qualifies the final byte of the image

## Operation
- Reset values: every output is 0, the FSM is in IDLE, and the FIFO and all counters are cleared. Asserting reset mid-operation aborts at once; there is no pending `done` or `err`.
- **IDLE / DONE / ERR → HDR** on `start`. This clears `err`.
- **HDR**
  - Issue reads at addresses 0..53, one per cycle, with `rom_valid` held high for 54 consecutive cycles.
  - Capture each returned byte the cycle after it is issued.
  - Store bytes 0–1 (magic), 10–13 (pixel offset `off`), 18–21 (width), 22–25 (height) and 28–29 (bpp). All fields are little-endian.
- **CHECK** (1 cycle)
  - Compute `row = width*bpp/8`, `stride = (row+3) & ~3` and `total = stride*height`. Use at least 2·ADDR_WIDTH bits internally with no truncation.
  - Go to ERR if any of these hold:
    - magic ≠ 0x42,0x4D
    - bpp ∉ {8, 24}
    - width = 0 or height = 0
    - `off + total > 2^ADDR_WIDTH`
  - Otherwise go to STREAM.
- **STREAM**
  - Read addresses `off .. off+total-1` in ascending order.
  - Returned bytes enter a 2-entry FIFO whose head drives `pix_data`.
  - A read is issued only when FIFO occupancy plus reads in flight < 2, so data is never lost or duplicated.
  - `pix_last` is high exactly while the FIFO head is byte `total-1`.
  - After the final handshake, go to DONE.
- **DONE** (1 cycle): `done` = 1, `busy` = 0, then IDLE.
- **ERR**: `err` = 1 and `rom_valid` = 0. The block stays in ERR until `start`.
- `start` while `busy` is ignored.
- `pix_valid` never drops without a handshake. `pix_data` and `pix_last` are stable while `pix_valid && !pix_ready`.
- `rom_valid` is low outside HDR and STREAM and after the last STREAM address is issued.

## Timing
- `start` is sampled at cycle T.
- HDR reads addresses 0..53 at T+1..T+54. The last header byte is captured at T+55.
- CHECK runs at T+56.
- The first STREAM read is issued at T+57 and `pix_valid` first rises at T+58. Start-to-first-byte latency is 58 cycles.
- With `pix_ready` held at 1, one byte transfers per cycle with no bubbles. The final handshake occurs at T+57+total.
- `done` pulses the cycle after the final handshake, with `busy` low in the same cycle.
- On an error, `err` rises at T+57 with `busy` low. No stream bytes are produced.
- After backpressure is released, the first handshake occurs in the same cycle that `pix_ready` rises, provided `pix_valid` is already high.

## Test plan
- 8 bpp, 4×2 image, `off` = 1078 → reads 1078..1085; 8 bytes out in order; `pix_last` on the 8th; `done` pulses at T+66.
- 24 bpp, 3×2 image, `off` = 54 → stride 12, total 24; addresses 54..77; padding bytes 63–65 and 75–77 are streamed; `pix_last` on the 24th.
- Magic byte 0 = 0x41 → `err` = 1 at T+57; `pix_valid` never rises; a second `start` clears `err` and restarts the header reads.
- bpp = 32 → ERR. Separately, `off + total` = 2^ADDR_WIDTH + 1 → ERR.
- Random `pix_ready` (50% duty) on the 24 bpp case → all 24 bytes match ROM in order with no duplicates; at most 2 reads are outstanding; outputs are stable during stalls.
- `start` pulsed mid-STREAM → ignored. `rst_n` low mid-STREAM → every output is 0 immediately and the FSM is in IDLE; a fresh `start` completes normally.
